tag_resolver: RTL

TAG_RESOLVER -- requirements
Module: tag_resolver

---
 rtl/tag_resolver.sv | 99 +++++++++
 1 files changed

// File: rtl/tag_resolver.sv
// Tag resolver: captures a responder tag vector and emits set-bit indices in
// ascending order over a valid/ready handshake, one index per cycle.
module tag_resolver #(
   parameter int unsigned N  = 100,
   parameter int unsigned IW = 7
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [N-1:0]  tags,
   input  logic          start,
   input  logic          idx_ready,
   output logic          idx_valid,
   output logic [IW-1:0] idx,
   output logic          last,
   output logic          busy,
   output logic [IW-1:0] count,
   output logic          done,
   output logic          none
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  pending_q, pending_d;
   logic [IW-1:0] count_q, count_d;
   logic          none_q, none_d;
   logic [IW-1:0] lowest;
   logic          single;

   // Priority-encode the lowest set bit of the pending vector.
   always_comb begin
      lowest = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) lowest = IW'(i);
      end
   end

   // Exactly one responder left means the presented index is the final one.
   assign single = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         pending_q <= '0;
         count_q   <= '0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         none_q    <= none_d;
      end
   end

   // Next-state: capture in idle, retire one index per accepted transfer.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      none_d    = none_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               pending_d = tags;
               count_d   = '0;
               none_d    = (tags == '0);
               state_d   = (tags == '0) ? StDone : StScan;
            end
         end
         StScan: begin
            if (idx_ready) begin
               pending_d = pending_q & ~({{(N-1){1'b0}}, 1'b1} << lowest);
               count_d   = count_q + IW'(1);
               if (single) state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from the current state; idx is forced to 0 outside scan.
   always_comb begin
      idx_valid = (state_q == StScan);
      idx       = (state_q == StScan) ? lowest : '0;
      last      = (state_q == StScan) && single;
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
   end

   assign count = count_q;
   assign none  = none_q;

endmodule
